// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags feeding rename, refilled by commit.
// The head pointer can be checkpointed per branch column and rolled back in one cycle.
module phys_reg_free_list #(
    parameter int NUM_PHYS_REGS      = 64,
    parameter int NUM_ARCH_REGS      = 32,
    parameter int CHECKPOINT_COLUMNS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       dequeue_valid,
    output logic [5:0] dequeue_phys_reg_tag,
    input  logic       dequeue_ready,
    input  logic       enqueue_valid,
    input  logic [5:0] enqueue_phys_reg_tag,
    input  logic       save_checkpoint_valid,
    input  logic [1:0] save_checkpoint_column,
    input  logic       restore_checkpoint_valid,
    input  logic [1:0] restore_checkpoint_column,
    output logic [5:0] free_count,
    output logic       overflow_error
);
    localparam int PHYS_REG_WIDTH      = 6;
    localparam int FREE_LIST_DEPTH     = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int LOG_FREE_LIST_DEPTH = 5;

    logic [PHYS_REG_WIDTH-1:0]      tag_mem_reg [FREE_LIST_DEPTH];
    logic [LOG_FREE_LIST_DEPTH:0]   head_reg, head_next;
    logic [LOG_FREE_LIST_DEPTH:0]   tail_reg, tail_next;
    logic [LOG_FREE_LIST_DEPTH:0]   ckpt_head_reg [CHECKPOINT_COLUMNS];
    logic                           overflow_error_reg;
    logic [FREE_LIST_DEPTH-1:0]     entry_we;
    logic [CHECKPOINT_COLUMNS-1:0]  ckpt_we;

    logic empty, full, deq_fire, enq_fire;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty    = (head_reg == tail_reg);
    assign full     = (head_reg[LOG_FREE_LIST_DEPTH-1:0] == tail_reg[LOG_FREE_LIST_DEPTH-1:0]) &&
                      (head_reg[LOG_FREE_LIST_DEPTH] != tail_reg[LOG_FREE_LIST_DEPTH]);
    assign deq_fire = !empty && dequeue_ready && !restore_checkpoint_valid;
    assign enq_fire = enqueue_valid && !full;

    always_comb begin
        head_next = head_reg;
        if (restore_checkpoint_valid)
            head_next = ckpt_head_reg[restore_checkpoint_column];
        else if (deq_fire)
            head_next = head_reg + 1'b1;
    end

    always_comb begin
        tail_next = tail_reg;
        if (enq_fire)
            tail_next = tail_reg + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < FREE_LIST_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = enq_fire && (tail_reg[LOG_FREE_LIST_DEPTH-1:0] == gi[LOG_FREE_LIST_DEPTH-1:0]);
        end
        for (gi = 0; gi < CHECKPOINT_COLUMNS; gi++) begin : g_ckpt_we
            assign ckpt_we[gi] = save_checkpoint_valid && (save_checkpoint_column == gi[1:0]);
        end
    endgenerate

    // The list starts full with every non-architectural tag, in ascending order.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
            if (RST)
                tag_mem_reg[i] <= PHYS_REG_WIDTH'(NUM_ARCH_REGS + i);
            else if (entry_we[i])
                tag_mem_reg[i] <= enqueue_phys_reg_tag;
        end
    end

    // Saving head_next lets a branch keep its own same-cycle allocation.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < CHECKPOINT_COLUMNS; i++) begin
            if (RST)
                ckpt_head_reg[i] <= '0;
            else if (ckpt_we[i])
                ckpt_head_reg[i] <= head_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_reg           <= '0;
            tail_reg           <= (LOG_FREE_LIST_DEPTH+1)'(FREE_LIST_DEPTH);
            overflow_error_reg <= 1'b0;
        end else begin
            head_reg           <= head_next;
            tail_reg           <= tail_next;
            overflow_error_reg <= enqueue_valid && full;
        end
    end

    assign dequeue_valid        = !empty;
    assign dequeue_phys_reg_tag = tag_mem_reg[head_reg[LOG_FREE_LIST_DEPTH-1:0]];
    assign free_count           = tail_reg - head_reg;
    assign overflow_error       = overflow_error_reg;
endmodule
